// File: rtl/bloom_filter_csr_mc.sv
// Avalon-MM CSR block for the bloom filter: control/status, saturating per-channel match
// counters read through a LO/HI snapshot, and a hash-LUT clean sequencer with timeout and IRQ.
module bloom_filter_csr_mc #(
    parameter int          AMM_CSR_ADDR_W = 8,
    parameter int          AMM_CSR_DATA_W = 32,
    parameter int          CH_CNT         = 4,
    parameter int          CNT_W          = 48,
    parameter int          CLEAN_TIMEOUT  = 65535,
    parameter logic [31:0] VERSION        = 32'h0002_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AMM_CSR_ADDR_W-1:0] amm_slave_csr_address_i,
    input  logic                      amm_slave_csr_read_i,
    output logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_readdata_o,
    output logic                      amm_slave_csr_readdatavalid_o,
    input  logic                      amm_slave_csr_write_i,
    input  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_writedata_i,
    input  logic [CH_CNT-1:0]         match_stb_i,
    output logic                      en_o,
    output logic                      hash_lut_clean_stb_o,
    input  logic                      hash_lut_clean_done_i,
    output logic                      irq_o
);
    localparam int DW    = AMM_CSR_DATA_W;
    localparam int SH_W  = CNT_W - DW;
    localparam int IDX_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
    localparam int TMO_W = (CLEAN_TIMEOUT > 1) ? $clog2(CLEAN_TIMEOUT) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(CLEAN_TIMEOUT - 1);
    localparam logic [DW-1:0]    VERSION_W = DW'(VERSION);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [31:0] A_CTRL    = 32'd0;
    localparam logic [31:0] A_STATUS  = 32'd1;
    localparam logic [31:0] A_CLEAN   = 32'd2;
    localparam logic [31:0] A_CNT_CLR = 32'd3;
    localparam logic [31:0] A_SCRATCH = 32'd4;
    localparam logic [31:0] A_VERSION = 32'd5;
    localparam logic [31:0] A_CNT_LO  = 32'd8;
    localparam logic [31:0] A_CNT_END = 32'(8 + 2 * CH_CNT);

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             timeout_q, timeout_d;
    logic             irq_pend_q, irq_pend_d;
    logic [DW-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q [CH_CNT];
    logic [CNT_W-1:0] cnt_d [CH_CNT];
    logic [SH_W-1:0]  shadow_q [CH_CNT];
    logic [SH_W-1:0]  shadow_d [CH_CNT];
    logic [CH_CNT-1:0] sat_q, sat_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             rvalid_q;

    logic [31:0]       addr_u;
    logic              wr_ctrl, wr_status, wr_clean, wr_cnt_clr, wr_scratch;
    logic              cnt_hit, cnt_is_hi, lo_rd;
    logic [IDX_W-1:0]  cnt_idx;
    logic [CH_CNT-1:0] clr_mask;
    logic              busy, clean_end, tmo_hit;

    assign addr_u     = 32'(amm_slave_csr_address_i);
    assign wr_ctrl    = amm_slave_csr_write_i && (addr_u == A_CTRL);
    assign wr_status  = amm_slave_csr_write_i && (addr_u == A_STATUS);
    assign wr_clean   = amm_slave_csr_write_i && (addr_u == A_CLEAN);
    assign wr_cnt_clr = amm_slave_csr_write_i && (addr_u == A_CNT_CLR);
    assign wr_scratch = amm_slave_csr_write_i && (addr_u == A_SCRATCH);

    // Counter window: even word = LO of channel (addr-8)/2, odd word = its HI shadow.
    assign cnt_hit   = (addr_u >= A_CNT_LO) && (addr_u < A_CNT_END);
    assign cnt_idx   = IDX_W'((addr_u - A_CNT_LO) >> 1);
    assign cnt_is_hi = addr_u[0];
    assign lo_rd     = amm_slave_csr_read_i && cnt_hit && !cnt_is_hi;
    assign clr_mask  = wr_cnt_clr ? CH_CNT'(amm_slave_csr_writedata_i) : '0;

    assign busy                 = (state_q != ST_IDLE);
    assign en_o                 = ctrl_q[0] & ~busy;
    assign hash_lut_clean_stb_o = (state_q == ST_PULSE);
    assign irq_o                = irq_pend_q & ctrl_q[2];

    assign amm_slave_csr_readdata_o      = rdata_q;
    assign amm_slave_csr_readdatavalid_o = rvalid_q;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        clean_end = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_clean && amm_slave_csr_writedata_i[0]) begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                // done is checked first so a coincident timeout is not reported
                if (hash_lut_clean_done_i) begin
                    state_d   = ST_IDLE;
                    clean_end = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    clean_end = 1'b1;
                    tmo_hit   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d     = wr_ctrl ? amm_slave_csr_writedata_i[2:0] : ctrl_q;
        scratch_d  = wr_scratch ? amm_slave_csr_writedata_i : scratch_q;
        timeout_d  = timeout_q;
        irq_pend_d = irq_pend_q;
        if (wr_status && amm_slave_csr_writedata_i[1]) timeout_d  = 1'b0;
        if (wr_status && amm_slave_csr_writedata_i[3]) irq_pend_d = 1'b0;
        if (tmo_hit)   timeout_d  = 1'b1;
        if (clean_end) irq_pend_d = 1'b1;
    end

    always_comb begin
        logic ch_clr;
        logic ch_inc;
        ch_clr = 1'b0;
        ch_inc = 1'b0;
        for (int unsigned n = 0; n < CH_CNT; n++) begin
            cnt_d[n]    = cnt_q[n];
            sat_d[n]    = sat_q[n];
            shadow_d[n] = shadow_q[n];
            ch_clr      = clr_mask[n] | (lo_rd & ctrl_q[1] & (cnt_idx == IDX_W'(n)));
            ch_inc      = en_o & match_stb_i[n];
            if (lo_rd && (cnt_idx == IDX_W'(n))) begin
                shadow_d[n] = cnt_q[n][CNT_W-1:DW];
            end
            // a clear coinciding with a match keeps that match as the first new count
            if (ch_clr) begin
                cnt_d[n] = ch_inc ? CNT_W'(1) : '0;
                sat_d[n] = 1'b0;
            end else if (ch_inc) begin
                if (&cnt_q[n]) begin
                    sat_d[n] = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (addr_u)
            A_CTRL:    rdata_d = DW'(ctrl_q);
            A_STATUS:  rdata_d = DW'({irq_pend_q, |sat_q, timeout_q, busy});
            A_SCRATCH: rdata_d = scratch_q;
            A_VERSION: rdata_d = VERSION_W;
            default: begin
                if (cnt_hit) begin
                    rdata_d = cnt_is_hi ? DW'(shadow_q[cnt_idx]) : cnt_q[cnt_idx][DW-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            ctrl_q     <= '0;
            timeout_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            scratch_q  <= '0;
            sat_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            for (int unsigned n = 0; n < CH_CNT; n++) begin
                cnt_q[n]    <= '0;
                shadow_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            ctrl_q     <= ctrl_d;
            timeout_q  <= timeout_d;
            irq_pend_q <= irq_pend_d;
            scratch_q  <= scratch_d;
            sat_q      <= sat_d;
            rvalid_q   <= amm_slave_csr_read_i;
            if (amm_slave_csr_read_i) begin
                rdata_q <= rdata_d;
            end
            for (int unsigned n = 0; n < CH_CNT; n++) begin
                cnt_q[n]    <= cnt_d[n];
                shadow_q[n] <= shadow_d[n];
            end
        end
    end

endmodule
